// File: rtl/axis_if.sv
// AXI-Stream handshake bundle: data, end-of-packet marker, valid/ready.
// The master modport drives a stream and the slave modport receives one.
interface axis_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO that stores tlast alongside tdata. It has an optional store-and-forward
// packet mode, a fill level and a complete-packet count, almost-full/almost-empty flags and
// a synchronous flush. The read side is first-word-fall-through. Pointers wrap explicitly,
// so FIFO_DEPTH does not have to be a power of two.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 16,
    parameter int PACKET_MODE     = 0,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 2,
    localparam int LW             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic          flush_i,
    axis_if.slave         s_axis,
    axis_if.master        m_axis,
    output logic [LW-1:0] level_o,
    output logic [LW-1:0] pkt_count_o,
    output logic          almost_full_o,
    output logic          almost_empty_o
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_TH);
    localparam logic [LW-1:0] AE_L    = LW'(ALMOST_EMPTY_TH);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("axis_pkt_fifo: DATA_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("axis_pkt_fifo: FIFO_DEPTH must be >= 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > FIFO_DEPTH) begin : g_bad_af
        $error("axis_pkt_fifo: ALMOST_FULL_TH out of range");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("axis_pkt_fifo: ALMOST_EMPTY_TH out of range");
    end

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic [LW-1:0]       pkt_count;
    logic                ready_en;
    logic                s_ready;
    logic                m_valid;
    logic                m_last;
    logic                push;
    logic                pop;
    logic                pkt_in;
    logic                pkt_out;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on registered state and flush, never on m_tready.
    assign s_ready = ready_en && (level != DEPTH_L) && !flush_i;

    // In packet mode, hold data back until a whole packet is stored. A full FIFO with no
    // complete packet is released in cut-through so oversize packets cannot deadlock.
    assign m_valid = (level != '0) &&
                     ((PACKET_MODE == 0) || (pkt_count != '0) || (level == DEPTH_L));

    assign m_last  = mem[rd_ptr][DATA_WIDTH];
    assign push    = s_axis.tvalid && s_ready;
    assign pop     = m_valid && m_axis.tready;
    assign pkt_in  = push && s_axis.tlast;
    assign pkt_out = pop && m_last;

    assign s_axis.tready  = s_ready;
    assign m_axis.tvalid  = m_valid;
    assign m_axis.tdata   = mem[rd_ptr][DATA_WIDTH-1:0];
    assign m_axis.tlast   = m_last;

    assign level_o        = level;
    assign pkt_count_o    = pkt_count;
    assign almost_full_o  = (level >= AF_L);
    assign almost_empty_o = (level <= AE_L);

    // Keep s_tready low while in reset and raise it on the first clock after release.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Storage write port. The contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // Pointer, level and packet-count bookkeeping. Flush takes priority over push and pop.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + LW'(1);
                2'b01:   pkt_count <= pkt_count - LW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo with three instances:
//   A: depth 16, cut-through; B: depth 5, cut-through; C: depth 4, packet mode.
// Each instance is compared on every falling edge against a queue-based reference.
// Directed sequences add literal expectations on top of that comparison.
module tb_axis_pkt_fifo;
    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    axis_if #(.DATA_WIDTH(16)) a_s ();
    axis_if #(.DATA_WIDTH(16)) a_m ();
    axis_if #(.DATA_WIDTH(16)) b_s ();
    axis_if #(.DATA_WIDTH(16)) b_m ();
    axis_if #(.DATA_WIDTH(16)) c_s ();
    axis_if #(.DATA_WIDTH(16)) c_m ();

    logic       a_flush, b_flush, c_flush;
    logic [4:0] a_level, a_pkt;
    logic [2:0] b_level, b_pkt, c_level, c_pkt;
    logic       a_af, a_ae, b_af, b_ae, c_af, c_ae;

    axis_pkt_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .PACKET_MODE(0),
                    .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)) u_a (
        .clk_i(clk), .arstn_i(arstn), .flush_i(a_flush), .s_axis(a_s), .m_axis(a_m),
        .level_o(a_level), .pkt_count_o(a_pkt), .almost_full_o(a_af), .almost_empty_o(a_ae));

    axis_pkt_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .PACKET_MODE(0),
                    .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) u_b (
        .clk_i(clk), .arstn_i(arstn), .flush_i(b_flush), .s_axis(b_s), .m_axis(b_m),
        .level_o(b_level), .pkt_count_o(b_pkt), .almost_full_o(b_af), .almost_empty_o(b_ae));

    axis_pkt_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .PACKET_MODE(1),
                    .ALMOST_FULL_TH(3), .ALMOST_EMPTY_TH(1)) u_c (
        .clk_i(clk), .arstn_i(arstn), .flush_i(c_flush), .s_axis(c_s), .m_axis(c_m),
        .level_o(c_level), .pkt_count_o(c_pkt), .almost_full_o(c_af), .almost_empty_o(c_ae));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference contents per instance: each entry is {tlast, tdata}, head first.
    logic [16:0] mq [3][$];
    bit          live [3];

    task automatic model_cycle(
        input int idx, input int depth, input int mode, input int aft, input int aet,
        input string tag, input logic rst_n, input logic flush,
        input logic svalid, input logic [15:0] sdata, input logic slast, input logic mready,
        input logic a_sready, input logic a_mvalid, input logic [15:0] a_mdata,
        input logic a_mlast, input logic [7:0] a_level, input logic [7:0] a_pkt,
        input logic a_af, input logic a_ae);
        int   n;
        int   np;
        logic er;
        logic ev;
        if (!rst_n) begin
            mq[idx].delete();
            live[idx] = 1'b0;
            chk({tag, " rst s_tready"}, a_sready, 0);
            chk({tag, " rst m_tvalid"}, a_mvalid, 0);
            chk({tag, " rst level"}, a_level, 0);
            chk({tag, " rst pkt_count"}, a_pkt, 0);
            chk({tag, " rst almost_full"}, a_af, 0);
            chk({tag, " rst almost_empty"}, a_ae, 1);
            return;
        end
        n  = mq[idx].size();
        np = 0;
        for (int k = 0; k < n; k++) begin
            if (mq[idx][k][16]) np++;
        end
        er = live[idx] && (n != depth) && !flush;
        ev = (n != 0) && (mode == 0 || np != 0 || n == depth);
        chk({tag, " s_tready"}, a_sready, er);
        chk({tag, " m_tvalid"}, a_mvalid, ev);
        if (ev) begin
            chk({tag, " m_tdata"}, a_mdata, mq[idx][0][15:0]);
            chk({tag, " m_tlast"}, a_mlast, mq[idx][0][16]);
        end
        chk({tag, " level"}, a_level, n);
        chk({tag, " pkt_count"}, a_pkt, np);
        chk({tag, " almost_full"}, a_af, n >= aft);
        chk({tag, " almost_empty"}, a_ae, n <= aet);
        if (flush) begin
            mq[idx].delete();
        end else begin
            if (ev && mready) void'(mq[idx].pop_front());
            if (er && svalid) mq[idx].push_back({slast, sdata});
        end
        live[idx] = 1'b1;
    endtask

    always @(negedge clk)
        model_cycle(0, 16, 0, 12, 2, "A", arstn, a_flush, a_s.tvalid, a_s.tdata, a_s.tlast,
                    a_m.tready, a_s.tready, a_m.tvalid, a_m.tdata, a_m.tlast,
                    8'(a_level), 8'(a_pkt), a_af, a_ae);
    always @(negedge clk)
        model_cycle(1, 5, 0, 4, 1, "B", arstn, b_flush, b_s.tvalid, b_s.tdata, b_s.tlast,
                    b_m.tready, b_s.tready, b_m.tvalid, b_m.tdata, b_m.tlast,
                    8'(b_level), 8'(b_pkt), b_af, b_ae);
    always @(negedge clk)
        model_cycle(2, 4, 1, 3, 1, "C", arstn, c_flush, c_s.tvalid, c_s.tdata, c_s.tlast,
                    c_m.tready, c_s.tready, c_m.tvalid, c_m.tdata, c_m.tlast,
                    8'(c_level), 8'(c_pkt), c_af, c_ae);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int sent, got, cyc;
    bit drain, push_ok, pop_ok;

    initial begin
        arstn = 1'b0;
        a_flush = 0; b_flush = 0; c_flush = 0;
        a_s.tvalid = 0; a_s.tdata = '0; a_s.tlast = 0; a_m.tready = 0;
        b_s.tvalid = 0; b_s.tdata = '0; b_s.tlast = 0; b_m.tready = 0;
        c_s.tvalid = 0; c_s.tdata = '0; c_s.tlast = 0; c_m.tready = 0;
        repeat (3) tick();
        arstn = 1'b1;
        tick();
        chk("A s_tready after release", a_s.tready, 1);
        chk("A almost_empty after release", a_ae, 1);

        // Fill A completely, try one blocked push, then drain in order.
        for (int i = 1; i <= 16; i++) begin
            a_s.tvalid = 1; a_s.tdata = 16'(i); a_s.tlast = (i == 16);
            tick();
        end
        a_s.tdata = 16'h0FFF; a_s.tlast = 0;
        tick();
        chk("A full level", a_level, 16);
        chk("A full s_tready", a_s.tready, 0);
        chk("A full almost_full", a_af, 1);
        a_s.tvalid = 0;
        a_m.tready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk("A drain data", a_m.tdata, 16'(i));
            tick();
        end
        chk("A drained level", a_level, 0);
        chk("A drained m_tvalid", a_m.tvalid, 0);
        chk("A drained almost_empty", a_ae, 1);
        a_m.tready = 0;

        // B: 23 beats with random valid/ready through a depth-5 FIFO.
        sent = 0; got = 0; cyc = 0;
        while (got < 23 && cyc < 600) begin
            b_s.tvalid = (sent < 23) && ($urandom_range(0, 3) != 0);
            b_s.tdata  = 16'h0100 + 16'(sent);
            b_s.tlast  = (sent % 4 == 3) || (sent == 22);
            b_m.tready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            push_ok = b_s.tvalid && b_s.tready;
            pop_ok  = b_m.tvalid && b_m.tready;
            if (pop_ok) chk("B order", b_m.tdata, 16'h0100 + 16'(got));
            chk("B level bound", b_level <= 3'd5, 1);
            tick();
            if (push_ok) sent++;
            if (pop_ok) got++;
            cyc++;
        end
        chk("B all beats out", got, 23);
        b_s.tvalid = 0; b_m.tready = 0;
        tick();

        // C packet mode: 3-beat packet, data held until the tlast beat is stored.
        c_m.tready = 1;
        chk("C empty m_tvalid", c_m.tvalid, 0);
        c_s.tvalid = 1; c_s.tdata = 16'h00A1; c_s.tlast = 0;
        tick();
        chk("C beat1 m_tvalid", c_m.tvalid, 0);
        chk("C beat1 pkt_count", c_pkt, 0);
        c_s.tdata = 16'h00A2;
        tick();
        chk("C beat2 m_tvalid", c_m.tvalid, 0);
        c_s.tdata = 16'h00A3; c_s.tlast = 1;
        tick();
        c_s.tvalid = 0; c_s.tlast = 0;
        chk("C pkt m_tvalid", c_m.tvalid, 1);
        chk("C pkt pkt_count", c_pkt, 1);
        chk("C pkt first data", c_m.tdata, 16'h00A1);
        chk("C pkt first tlast", c_m.tlast, 0);
        tick();
        chk("C second data", c_m.tdata, 16'h00A2);
        chk("C second tlast", c_m.tlast, 0);
        tick();
        chk("C third data", c_m.tdata, 16'h00A3);
        chk("C third tlast", c_m.tlast, 1);
        tick();
        chk("C done m_tvalid", c_m.tvalid, 0);
        chk("C done pkt_count", c_pkt, 0);
        c_m.tready = 0;

        // C: 6-beat packet longer than depth 4 must not deadlock.
        sent = 0; got = 0; cyc = 0; drain = 0;
        while (got < 6 && cyc < 100) begin
            c_s.tvalid = (sent < 6);
            c_s.tdata  = 16'h00B0 + 16'(sent);
            c_s.tlast  = (sent == 5);
            c_m.tready = drain;
            @(negedge clk);
            if (!drain) begin
                if (c_level == 3'd4) begin
                    chk("C valid at full", c_m.tvalid, 1);
                    drain = 1;
                end else begin
                    chk("C held below full", c_m.tvalid, 0);
                end
            end
            push_ok = c_s.tvalid && c_s.tready;
            pop_ok  = c_m.tvalid && c_m.tready;
            if (pop_ok) begin
                chk("C long order", c_m.tdata, 16'h00B0 + 16'(got));
                chk("C long tlast", c_m.tlast, got == 5);
            end
            tick();
            if (push_ok) sent++;
            if (pop_ok) got++;
            cyc++;
        end
        chk("C long all out", got, 6);
        c_s.tvalid = 0; c_s.tlast = 0; c_m.tready = 0;
        tick();

        // A: hold level 3 with simultaneous push and pop for 10 cycles.
        a_s.tvalid = 1;
        a_s.tdata = 16'h0051; a_s.tlast = 0; tick();
        a_s.tdata = 16'h0052; a_s.tlast = 1; tick();
        a_s.tdata = 16'h0053; a_s.tlast = 0; tick();
        chk("A level before steady", a_level, 3);
        chk("A pkt before steady", a_pkt, 1);
        a_m.tready = 1;
        for (int i = 0; i < 10; i++) begin
            a_s.tdata = 16'h0060 + 16'(i); a_s.tlast = i[0];
            tick();
            chk("A steady level", a_level, 3);
        end
        chk("A steady pkt_count", a_pkt, 2);
        chk("A steady head", a_m.tdata, 16'h0067);
        a_s.tvalid = 0; a_s.tlast = 0;
        repeat (3) tick();
        chk("A steady drained", a_level, 0);
        a_m.tready = 0;

        // A: flush at level 7 with push and pop both offered.
        for (int i = 0; i < 7; i++) begin
            a_s.tvalid = 1; a_s.tdata = 16'h0070 + 16'(i); a_s.tlast = (i == 3);
            tick();
        end
        a_s.tdata = 16'h007F; a_s.tlast = 0;
        a_flush = 1; a_m.tready = 1;
        #1;
        chk("A pre-flush level", a_level, 7);
        chk("A flush s_tready", a_s.tready, 0);
        chk("A flush m_tvalid", a_m.tvalid, 1);
        tick();
        a_flush = 0; a_s.tvalid = 0; a_m.tready = 0;
        chk("A post-flush level", a_level, 0);
        chk("A post-flush pkt", a_pkt, 0);
        chk("A post-flush m_tvalid", a_m.tvalid, 0);
        tick();
        chk("A post-flush s_tready", a_s.tready, 1);

        // Asynchronous reset in the middle of traffic.
        a_s.tvalid = 1; a_s.tdata = 16'h0090; a_s.tlast = 1;
        repeat (3) tick();
        chk("A level before reset", a_level, 3);
        arstn = 1'b0;
        #1;
        chk("A async rst level", a_level, 0);
        chk("A async rst pkt", a_pkt, 0);
        chk("A async rst s_tready", a_s.tready, 0);
        chk("A async rst m_tvalid", a_m.tvalid, 0);
        chk("A async rst almost_empty", a_ae, 1);
        chk("A async rst almost_full", a_af, 0);
        a_s.tvalid = 0; a_s.tlast = 0;
        tick();
        arstn = 1'b1;
        tick();
        chk("A s_tready after second release", a_s.tready, 1);
        chk("A level after second release", a_level, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
